sirv_uart_tl_bridge: RTL and testbench

Debug/host bridge. Takes a byte stream (normally from uart_rx) and turns it into single TileLink-UL Get/PutFullData requests as a bus initiator. It returns status and read data as a byte stream (normally to sirv_uarttx). It is the initiator-side counterpart of the UART peripheral's TL responder: an external host drives the SoC peripheral bus over serial.

---
 rtl/sirv_uart_tl_bridge.sv | 258 +++++++++++++++++++++++++
 tb/tb_sirv_uart_tl_bridge.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sirv_uart_tl_bridge.sv
// UART byte-stream to TileLink-UL initiator bridge: parses R/W frames, issues one Get/PutFullData, streams status and read data back.
// Optional inter-byte timeout enabled by defining SIRV_UART_TL_BRIDGE_TIMEOUT_EN.
module sirv_uart_tl_bridge #(
   parameter int         ADDR_W         = 29,
   parameter logic [4:0] SOURCE_ID      = 5'd0,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_bits,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_bits,
   output logic              tl_a_valid,
   input  logic              tl_a_ready,
   output logic [2:0]        tl_a_bits_opcode,
   output logic [2:0]        tl_a_bits_param,
   output logic [2:0]        tl_a_bits_size,
   output logic [4:0]        tl_a_bits_source,
   output logic [ADDR_W-1:0] tl_a_bits_address,
   output logic [3:0]        tl_a_bits_mask,
   output logic [31:0]       tl_a_bits_data,
   input  logic              tl_d_valid,
   output logic              tl_d_ready,
   input  logic [2:0]        tl_d_bits_opcode,
   input  logic [31:0]       tl_d_bits_data,
   input  logic              tl_d_bits_error
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR      = 3'd1,
      ST_DATA      = 3'd2,
      ST_REQ       = 3'd3,
      ST_RESP_STAT = 3'd4,
      ST_RESP_DATA = 3'd5
   } state_e;

   localparam logic [7:0] CMD_READ    = 8'h52;
   localparam logic [7:0] CMD_WRITE   = 8'h57;
   localparam logic [7:0] STAT_OK     = 8'h00;
   localparam logic [7:0] STAT_ERR    = 8'h01;
   localparam logic [7:0] STAT_BADCMD = 8'hFF;

   state_e      state_q, state_d;
   logic        op_wr_q, op_wr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  status_q, status_d;
   logic        a_done_q, a_done_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_bits_q, out_bits_d;
   logic        a_valid_q, a_valid_d;
   logic        d_ready_q, d_ready_d;

   logic in_hs_s, out_hs_s, a_hs_s, d_hs_s;
   logic tmo_hit_s;

   assign in_hs_s  = in_valid & in_ready_q;
   assign out_hs_s = out_valid_q & out_ready;
   assign a_hs_s   = a_valid_q & tl_a_ready;
   // D beats only count once the A handshake has happened (this cycle or earlier).
   assign d_hs_s   = tl_d_valid & d_ready_q & (a_done_q | a_hs_s);

`ifdef SIRV_UART_TL_BRIDGE_TIMEOUT_EN
   localparam int TMO_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMO_W-1:0] tmo_q, tmo_d;

   assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Inter-byte idle counter, only live while a frame is being parsed.
   always_comb begin
      tmo_d = '0;
      if ((state_q == ST_ADDR) || (state_q == ST_DATA)) begin
         if (in_hs_s || tmo_hit_s) begin
            tmo_d = '0;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end else begin
         tmo_d = '0;
      end
   end

   // Timeout counter register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic [31:0] unused_tmo_s;
   assign tmo_hit_s    = 1'b0;
   assign unused_tmo_s = 32'(TIMEOUT_CYCLES);
`endif

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         op_wr_q     <= 1'b0;
         cnt_q       <= 2'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 32'd0;
         rdata_q     <= 32'd0;
         status_q    <= 8'd0;
         a_done_q    <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_bits_q  <= 8'd0;
         a_valid_q   <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_wr_q     <= op_wr_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         status_q    <= status_d;
         a_done_q    <= a_done_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_bits_q  <= out_bits_d;
         a_valid_q   <= a_valid_d;
         d_ready_q   <= d_ready_d;
      end
   end

   // Next-state and frame assembly.
   always_comb begin
      state_d  = state_q;
      op_wr_d  = op_wr_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      status_d = status_q;
      a_done_d = a_done_q;
      case (state_q)
         ST_IDLE: begin
            a_done_d = 1'b0;
            if (in_hs_s) begin
               if ((in_bits == CMD_READ) || (in_bits == CMD_WRITE)) begin
                  op_wr_d = (in_bits == CMD_WRITE);
                  cnt_d   = 2'd0;
                  state_d = ST_ADDR;
               end else begin
                  status_d = STAT_BADCMD;
                  state_d  = ST_RESP_STAT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (in_hs_s) begin
               addr_d[{cnt_q, 3'b000} +: 8] = in_bits;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = op_wr_q ? ST_DATA : ST_REQ;
               end else begin
                  state_d = ST_ADDR;
               end
            end else if (tmo_hit_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (in_hs_s) begin
               wdata_d[{cnt_q, 3'b000} +: 8] = in_bits;
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d = ST_REQ;
               end else begin
                  state_d = ST_DATA;
               end
            end else if (tmo_hit_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_REQ: begin
            if (a_hs_s) begin
               a_done_d = 1'b1;
            end else begin
               a_done_d = a_done_q;
            end
            if (d_hs_s) begin
               rdata_d  = tl_d_bits_data;
               status_d = tl_d_bits_error ? STAT_ERR : STAT_OK;
               state_d  = ST_RESP_STAT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RESP_STAT: begin
            if (out_hs_s) begin
               cnt_d   = 2'd0;
               state_d = (!op_wr_q && (status_q != STAT_BADCMD)) ? ST_RESP_DATA : ST_IDLE;
            end else begin
               state_d = ST_RESP_STAT;
            end
         end
         ST_RESP_DATA: begin
            if (out_hs_s) begin
               cnt_d   = cnt_q + 2'd1;
               state_d = (cnt_q == 2'd3) ? ST_IDLE : ST_RESP_DATA;
            end else begin
               state_d = ST_RESP_DATA;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered outputs are computed from the upcoming state so they line up with it.
   always_comb begin
      in_ready_d  = (state_d == ST_IDLE) || (state_d == ST_ADDR) || (state_d == ST_DATA);
      out_valid_d = (state_d == ST_RESP_STAT) || (state_d == ST_RESP_DATA);
      d_ready_d   = (state_d == ST_REQ);
      a_valid_d   = (state_d == ST_REQ) && !a_done_d;
      case (state_d)
         ST_RESP_STAT: out_bits_d = status_d;
         ST_RESP_DATA: out_bits_d = rdata_d[{cnt_d, 3'b000} +: 8];
         default:      out_bits_d = out_bits_q;
      endcase
   end

   logic unused_s;
   assign unused_s = ^{tl_d_bits_opcode, addr_q};

   assign in_ready          = in_ready_q;
   assign out_valid         = out_valid_q;
   assign out_bits          = out_bits_q;
   assign tl_a_valid        = a_valid_q;
   assign tl_d_ready        = d_ready_q;
   assign tl_a_bits_opcode  = op_wr_q ? 3'd0 : 3'd4;
   assign tl_a_bits_param   = 3'd0;
   assign tl_a_bits_size    = 3'd2;
   assign tl_a_bits_source  = SOURCE_ID;
   assign tl_a_bits_address = {addr_q[ADDR_W-1:2], 2'b00};
   assign tl_a_bits_mask    = 4'hF;
   assign tl_a_bits_data    = op_wr_q ? wdata_q : 32'd0;

endmodule

// File: tb/tb_sirv_uart_tl_bridge.sv
// Directed, table-driven bench for sirv_uart_tl_bridge with a zero-latency and a slow TL responder.
module tb_sirv_uart_tl_bridge;

   logic        clock, reset_n;
   logic        in_valid, in_ready;
   logic [7:0]  in_bits;
   logic        out_valid, out_ready;
   logic [7:0]  out_bits;
   logic        tl_a_valid, tl_a_ready;
   logic [2:0]  tl_a_bits_opcode, tl_a_bits_param, tl_a_bits_size;
   logic [4:0]  tl_a_bits_source;
   logic [28:0] tl_a_bits_address;
   logic [3:0]  tl_a_bits_mask;
   logic [31:0] tl_a_bits_data;
   logic        tl_d_valid, tl_d_ready;
   logic [2:0]  tl_d_bits_opcode;
   logic [31:0] tl_d_bits_data;
   logic        tl_d_bits_error;

   logic zl, a_ready_r, d_valid_r;
   int   tests, fails, a_cnt;
   logic [2:0]  cap_op, cap_param, cap_size;
   logic [4:0]  cap_src;
   logic [28:0] cap_addr;
   logic [3:0]  cap_mask;
   logic [31:0] cap_data;

   sirv_uart_tl_bridge #(.ADDR_W(29), .SOURCE_ID(5'd0), .TIMEOUT_CYCLES(16)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
      .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
      .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready),
      .tl_a_bits_opcode(tl_a_bits_opcode), .tl_a_bits_param(tl_a_bits_param),
      .tl_a_bits_size(tl_a_bits_size), .tl_a_bits_source(tl_a_bits_source),
      .tl_a_bits_address(tl_a_bits_address), .tl_a_bits_mask(tl_a_bits_mask),
      .tl_a_bits_data(tl_a_bits_data),
      .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready),
      .tl_d_bits_opcode(tl_d_bits_opcode), .tl_d_bits_data(tl_d_bits_data),
      .tl_d_bits_error(tl_d_bits_error)
   );

   // Zero-latency responder ties a_ready to d_ready and answers D in the A handshake cycle.
   assign tl_a_ready       = zl ? tl_d_ready : a_ready_r;
   assign tl_d_valid       = zl ? tl_a_valid : d_valid_r;
   assign tl_d_bits_opcode = 3'd1;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // A-channel handshake monitor.
   always @(negedge clock) begin
      if (reset_n && tl_a_valid && tl_a_ready) begin
         a_cnt     = a_cnt + 1;
         cap_op    = tl_a_bits_opcode;
         cap_param = tl_a_bits_param;
         cap_size  = tl_a_bits_size;
         cap_src   = tl_a_bits_source;
         cap_addr  = tl_a_bits_address;
         cap_mask  = tl_a_bits_mask;
         cap_data  = tl_a_bits_data;
      end
   end

   typedef struct {
      logic [71:0] frame;
      int          len;
      logic [31:0] rdata;
      logic        derr;
      int          acnt;
      logic [2:0]  op;
      logic [28:0] addr;
      logic [31:0] data;
      logic [39:0] resp;
      int          rlen;
   } vec_t;

   vec_t vecs [7];

   function automatic vec_t mkv(input logic [71:0] f, input int l, input logic [31:0] rd,
                                input logic e, input int ac, input logic [2:0] op,
                                input logic [28:0] ad, input logic [31:0] dt,
                                input logic [39:0] rs, input int rl);
      vec_t v;
      v.frame = f; v.len = l; v.rdata = rd; v.derr = e; v.acnt = ac;
      v.op = op; v.addr = ad; v.data = dt; v.resp = rs; v.rlen = rl;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clock);
      in_valid = 1'b1;
      in_bits  = b;
      while (!in_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic recv_byte(input string nm, input logic [7:0] exp);
      int n;
      n = 0;
      out_ready = 1'b1;
      @(negedge clock);
      while (!out_valid && n < 200) begin
         @(negedge clock);
         n++;
      end
      chk({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
      if (out_valid) chk(nm, {56'd0, out_bits}, {56'd0, exp});
      @(posedge clock);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic send_frame(input logic [71:0] f, input int l);
      logic [71:0] fb;
      fb = f;
      for (int i = 0; i < l; i++) send_byte(fb[8*i +: 8]);
   endtask

   task automatic run_vec(input vec_t v);
      logic [39:0] rb;
      rb = v.resp;
      tl_d_bits_data  = v.rdata;
      tl_d_bits_error = v.derr;
      a_cnt = 0;
      send_frame(v.frame, v.len);
      for (int i = 0; i < v.rlen; i++) recv_byte("resp_byte", rb[8*i +: 8]);
      @(negedge clock);
      chk("idle_out_valid", {63'd0, out_valid}, 64'd0);
      chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
      chk("a_count", 64'(a_cnt), 64'(v.acnt));
      if (v.acnt > 0) begin
         chk("a_opcode", {61'd0, cap_op}, {61'd0, v.op});
         chk("a_address", {35'd0, cap_addr}, {35'd0, v.addr});
         chk("a_data", {32'd0, cap_data}, {32'd0, v.data});
         chk("a_consts", {49'd0, cap_param, cap_size, cap_src, cap_mask},
             {49'd0, 3'd0, 3'd2, 5'd0, 4'hF});
      end
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic ok_flag;
      tests = 0; fails = 0; a_cnt = 0;
      zl = 1'b1; a_ready_r = 1'b0; d_valid_r = 1'b0;
      in_valid = 1'b0; in_bits = 8'd0; out_ready = 1'b0;
      tl_d_bits_data = 32'd0; tl_d_bits_error = 1'b0;
      reset_n = 1'b0;

      vecs[0] = mkv(72'h00_00_02_1E_00_00_00_18_57, 9, 32'h0, 1'b0, 1, 3'd0, 29'h18, 32'h0000021E, 40'h00, 1);
      vecs[1] = mkv(72'h00_00_00_18_52, 5, 32'h0000021E, 1'b0, 1, 3'd4, 29'h18, 32'h0, 40'h00_00_02_1E_00, 5);
      vecs[2] = mkv(72'h00_00_10_00_52, 5, 32'hDEADBEEF, 1'b1, 1, 3'd4, 29'h1000, 32'h0, 40'hDE_AD_BE_EF_01, 5);
      vecs[3] = mkv(72'h41, 1, 32'h0, 1'b0, 0, 3'd0, 29'h0, 32'h0, 40'hFF, 1);
      vecs[4] = mkv(72'h00_00_00_18_52, 5, 32'h12345678, 1'b0, 1, 3'd4, 29'h18, 32'h0, 40'h12_34_56_78_00, 5);
      vecs[5] = mkv(72'hAA_BB_CC_DD_12_34_56_7B_57, 9, 32'h0, 1'b1, 1, 3'd0, 29'h12345678, 32'hAABBCCDD, 40'h01, 1);
      vecs[6] = mkv(72'hF0_00_00_04_52, 5, 32'h80000001, 1'b0, 1, 3'd4, 29'h10000004, 32'h0, 40'h80_00_00_01_00, 5);

      // Reset values.
      #13;
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      chk("rst_outs", {53'd0, out_valid, tl_a_valid, tl_d_ready, out_bits},
          {53'd0, 1'b0, 1'b0, 1'b0, 8'd0});
      chk("rst_addr_data", {3'd0, tl_a_bits_address, tl_a_bits_data}, 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i]);

      // Slow responder with a stray early D beat that must be ignored.
      zl = 1'b0;
      a_cnt = 0;
      tl_d_bits_data = 32'hCAFEF00D;
      tl_d_bits_error = 1'b0;
      send_frame(72'h00_00_00_20_52, 5);
      begin
         int n;
         n = 0;
         while (!tl_a_valid && n < 20) begin
            @(posedge clock);
            #1;
            n++;
         end
      end
      chk("slow_a_valid", {63'd0, tl_a_valid}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock);
         #1;
         d_valid_r       = (i == 1);
         tl_d_bits_error = (i == 1);
         chk("slow_a_hold", {1'd0, tl_a_valid, tl_a_bits_opcode, tl_a_bits_address, tl_a_bits_data},
             {1'd0, 1'b1, 3'd4, 29'h20, 32'h0});
      end
      d_valid_r = 1'b0;
      tl_d_bits_error = 1'b0;
      a_ready_r = 1'b1;
      @(posedge clock);
      #1;
      a_ready_r = 1'b0;
      chk("slow_a_count1", 64'(a_cnt), 64'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clock);
         #1;
         chk("slow_wait_d", {62'd0, tl_a_valid, tl_d_ready}, {62'd0, 1'b0, 1'b1});
      end
      d_valid_r = 1'b1;
      @(posedge clock);
      #1;
      d_valid_r = 1'b0;
      recv_byte("slow_stat", 8'h00);
      recv_byte("slow_b0", 8'h0D);
      recv_byte("slow_b1", 8'hF0);
      recv_byte("slow_b2", 8'hFE);
      recv_byte("slow_b3", 8'hCA);
      chk("slow_a_count_end", 64'(a_cnt), 64'd1);
      zl = 1'b1;

      // Output backpressure during RESP_DATA.
      tl_d_bits_data = 32'h44332211;
      send_frame(72'h00_00_00_18_52, 5);
      recv_byte("bp_stat", 8'h00);
      recv_byte("bp_b0", 8'h11);
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("bp_hold", {54'd0, out_valid, in_ready, out_bits}, {54'd0, 1'b1, 1'b0, 8'h22});
      end
      @(posedge clock);
      #1;
      recv_byte("bp_b1", 8'h22);
      recv_byte("bp_b2", 8'h33);
      recv_byte("bp_b3", 8'h44);
      @(negedge clock);
      chk("bp_idle", {62'd0, out_valid, in_ready}, {62'd0, 1'b0, 1'b1});

      // Reset in the middle of the DATA phase.
      send_frame(72'h99_00_00_01_00_57, 6);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_outs", {52'd0, in_ready, out_valid, tl_a_valid, tl_d_ready, out_bits},
          {52'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
      chk("mid_rst_addr_data", {3'd0, tl_a_bits_address, tl_a_bits_data}, 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      run_vec(vecs[4]);

`ifdef SIRV_UART_TL_BRIDGE_TIMEOUT_EN
      // Partial frame abandoned after the inter-byte timeout.
      send_frame(72'h22_11_57, 3);
      ok_flag = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (out_valid || tl_a_valid) ok_flag = 1'b0;
      end
      chk("tmo_silent", {63'd0, ok_flag}, 64'd1);
      chk("tmo_in_ready", {63'd0, in_ready}, 64'd1);
      @(posedge clock);
      #1;
      run_vec(vecs[1]);
`else
      ok_flag = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
